mmio_devices: RTL and testbench



---
 rtl/mmio_devices.sv | 208 ++++++++++++++++++++
 tb/tb_mmio_devices.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_devices.sv
// Memory-mapped HEX/LEDR outputs, KEY/SW status registers with debouncing, and an interval timer.
// Optional: define MMIO_IRQ_EN to add the irq output and writable IE bits.
module mmio_devices #(
    parameter int                      DBITS     = 32,
    parameter int                      HEXDIGITS = 6,
    parameter int                      LEDRBITS  = 10,
    parameter int                      KEYBITS   = 4,
    parameter int                      SWBITS    = 10,
    parameter logic [HEXDIGITS*4-1:0]  HEXRESET  = 24'hFEDEAD,
    parameter int                      DEBOUNCE  = 500000,
    parameter int                      TICKDIV   = 50000,
    parameter logic [DBITS-1:0]        ADDRHEX   = 32'hFFFFF000,
    parameter logic [DBITS-1:0]        ADDRLEDR  = 32'hFFFFF020,
    parameter logic [DBITS-1:0]        ADDRKEY   = 32'hFFFFF080,
    parameter logic [DBITS-1:0]        ADDRSW    = 32'hFFFFF090,
    parameter logic [DBITS-1:0]        ADDRTIMER = 32'hFFFFF100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DBITS-1:0]         addr,
    input  logic [DBITS-1:0]         wdata,
    input  logic                     we,
    input  logic                     re,
    output logic [DBITS-1:0]         rdata,
    output logic                     hit,
    input  logic [KEYBITS-1:0]       KEY,
    input  logic [SWBITS-1:0]        SW,
    output logic [HEXDIGITS*4-1:0]   HEX,
    output logic [LEDRBITS-1:0]      LEDR
`ifdef MMIO_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int HEXW = HEXDIGITS * 4;
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int PW   = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
`ifdef MMIO_IRQ_EN
    localparam logic IE_EN = 1'b1;
`else
    localparam logic IE_EN = 1'b0;
`endif

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    // Flag update shared by all CTRL registers: clears first, then a new event wins.
    function automatic ctrl_t ctrl_next(ctrl_t c, logic wr, ctrl_t wv, logic rclr, logic evt);
        ctrl_t n;
        n = c;
        if (wr) begin
            n.rdy = c.rdy & wv.rdy;
            n.ovr = c.ovr & wv.ovr;
            n.ie  = IE_EN & wv.ie;
        end
        if (rclr)
            n.rdy = 1'b0;
        if (evt) begin
            if (n.rdy)
                n.ovr = 1'b1;
            n.rdy = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [DBITS-1:0] ctrl_rd(ctrl_t c);
        logic [DBITS-1:0] r;
        r    = '0;
        r[0] = c.rdy;
        r[2] = c.ovr;
        r[8] = c.ie;
        return r;
    endfunction

    logic sel_hex, sel_ledr, sel_kdata, sel_kctrl, sel_sdata, sel_sctrl, sel_tcnt, sel_tlim, sel_tctl;
    assign sel_hex   = (addr == ADDRHEX);
    assign sel_ledr  = (addr == ADDRLEDR);
    assign sel_kdata = (addr == ADDRKEY);
    assign sel_kctrl = (addr == ADDRKEY + DBITS'(4));
    assign sel_sdata = (addr == ADDRSW);
    assign sel_sctrl = (addr == ADDRSW + DBITS'(4));
    assign sel_tcnt  = (addr == ADDRTIMER);
    assign sel_tlim  = (addr == ADDRTIMER + DBITS'(4));
    assign sel_tctl  = (addr == ADDRTIMER + DBITS'(8));
    assign hit = sel_hex | sel_ledr | sel_kdata | sel_kctrl | sel_sdata | sel_sctrl
               | sel_tcnt | sel_tlim | sel_tctl;

    ctrl_t wv;
    assign wv = '{ie: wdata[8], ovr: wdata[2], rdy: wdata[0]};

    logic [KEYBITS-1:0] key_s1, key_s2, kdata;
    logic [SWBITS-1:0]  sw_s1, sw_s2, sw_prev, sdata;
    logic [DBW-1:0]     sw_cnt, sw_cnt_next;
    logic [DBITS-1:0]   tcnt, tlim;
    logic [PW-1:0]      presc;
    ctrl_t              kctrl, sctrl, tctl;
    logic               key_evt, sw_load, tick, t_wrap, t_evt, wr_tcnt, wr_tlim;

    always_comb begin
        // NOTE: default first so no path leaves rdata unassigned (no latch).
        rdata = '0;
        if (sel_hex)        rdata[HEXW-1:0]     = HEX;
        else if (sel_ledr)  rdata[LEDRBITS-1:0] = LEDR;
        else if (sel_kdata) rdata[KEYBITS-1:0]  = kdata;
        else if (sel_kctrl) rdata               = ctrl_rd(kctrl);
        else if (sel_sdata) rdata[SWBITS-1:0]   = sdata;
        else if (sel_sctrl) rdata               = ctrl_rd(sctrl);
        else if (sel_tcnt)  rdata               = tcnt;
        else if (sel_tlim)  rdata               = tlim;
        else if (sel_tctl)  rdata               = ctrl_rd(tctl);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every block sees pre-edge values.
        if (reset) begin
            HEX  <= HEXRESET;
            LEDR <= '0;
        end else begin
            if (we && sel_hex)  HEX  <= wdata[HEXW-1:0];
            if (we && sel_ledr) LEDR <= wdata[LEDRBITS-1:0];
        end
    end

    // KEY is active-low on the pins; KDATA holds pressed=1.
    assign key_evt = (key_s2 != kdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '0;
            key_s2 <= '0;
            kdata  <= '0;
            kctrl  <= '0;
        end else begin
            key_s1 <= ~KEY;
            key_s2 <= key_s1;
            if (key_evt) kdata <= key_s2;
            kctrl <= ctrl_next(kctrl, we & sel_kctrl, wv, re & sel_kdata, key_evt);
        end
    end

    // sw_cnt counts consecutive cycles the synced value has differed from SDATA unchanged.
    always_comb begin
        sw_cnt_next = '0;
        if (sw_s2 != sdata)
            sw_cnt_next = (sw_s2 == sw_prev) ? sw_cnt + DBW'(1) : DBW'(1);
        sw_load = (sw_cnt_next == DBW'(DEBOUNCE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
            sw_cnt  <= '0;
            sdata   <= '0;
            sctrl   <= '0;
        end else begin
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
            sw_cnt  <= sw_load ? '0 : sw_cnt_next;
            if (sw_load) sdata <= sw_s2;
            sctrl <= ctrl_next(sctrl, we & sel_sctrl, wv, re & sel_sdata, sw_load);
        end
    end

    assign wr_tcnt = we & sel_tcnt;
    assign wr_tlim = we & sel_tlim;
    assign tick    = (presc == PW'(TICKDIV - 1));
    assign t_wrap  = (tlim != '0) && (tcnt == tlim - DBITS'(1));
    assign t_evt   = tick & t_wrap & ~wr_tcnt & ~wr_tlim;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt  <= '0;
            tlim  <= '0;
            presc <= '0;
            tctl  <= '0;
        end else begin
            if (wr_tlim) begin
                tlim  <= wdata;
                tcnt  <= '0;
                presc <= '0;
            end else if (wr_tcnt) begin
                tcnt  <= wdata;
                presc <= '0;
            end else begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) tcnt <= t_wrap ? '0 : tcnt + DBITS'(1);
            end
            tctl <= ctrl_next(tctl, we & sel_tctl, wv, 1'b0, t_evt);
        end
    end

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= (kctrl.rdy & kctrl.ie) | (sctrl.rdy & sctrl.ie) | (tctl.rdy & tctl.ie);
    end
`endif

endmodule

// File: tb/tb_mmio_devices.sv
// Scoreboard bench for mmio_devices (DEBOUNCE=4, TICKDIV=4); covers irq when MMIO_IRQ_EN is defined.
module tb_mmio_devices;

    localparam logic [31:0] A_HEX   = 32'hFFFFF000;
    localparam logic [31:0] A_LEDR  = 32'hFFFFF020;
    localparam logic [31:0] A_NONE  = 32'hFFFFF040;
    localparam logic [31:0] A_KDATA = 32'hFFFFF080;
    localparam logic [31:0] A_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] A_SDATA = 32'hFFFFF090;
    localparam logic [31:0] A_SCTRL = 32'hFFFFF094;
    localparam logic [31:0] A_TCNT  = 32'hFFFFF100;
    localparam logic [31:0] A_TLIM  = 32'hFFFFF104;
    localparam logic [31:0] A_TCTL  = 32'hFFFFF108;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, hit;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [23:0] HEX;
    logic [9:0]  LEDR;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    mmio_devices #(.DEBOUNCE(4), .TICKDIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .hit   (hit),
        .KEY   (KEY),
        .SW    (SW),
        .HEX   (HEX),
        .LEDR  (LEDR)
`ifdef MMIO_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    typedef struct {
        string       name;
        logic [32:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] obs_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Expected bus result for a mapped register: {hit, rdata}.
    function automatic logic [32:0] m(input logic [31:0] v);
        return {1'b1, v};
    endfunction

    task automatic push_exp(input string nm, input logic [32:0] e);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic ld, input logic [32:0] e);
        addr = a; re = ld; we = 1'b0;
        push_exp(nm, e);
        @(negedge clk);
        obs_q.push_back({hit, rdata});
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic rw(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [32:0] e);
        addr = a; wdata = d; we = 1'b1; re = 1'b1;
        push_exp(nm, e);
        @(negedge clk);
        obs_q.push_back({hit, rdata});
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset();
        exp_t x; logic [32:0] o;
        rd("rst_tcnt",  A_TCNT,  1'b0, m(32'h0));
        rd("rst_hex",   A_HEX,   1'b0, m(32'h00FEDEAD));
        rd("rst_ledr",  A_LEDR,  1'b0, m(32'h0));
        rd("rst_kdata", A_KDATA, 1'b0, m(32'h0));
        rd("rst_kctrl", A_KCTRL, 1'b0, m(32'h0));
        rd("rst_sdata", A_SDATA, 1'b0, m(32'h0));
        rd("rst_sctrl", A_SCTRL, 1'b0, m(32'h0));
        rd("rst_tlim",  A_TLIM,  1'b0, m(32'h0));
        rd("rst_tctl",  A_TCTL,  1'b0, m(32'h0));
        rd("rst_unmapped", A_NONE, 1'b0, 33'h0);
        push_exp("rst_hex_port", 33'(24'hFEDEAD));
        @(negedge clk);
        obs_q.push_back(33'(HEX));
        @(posedge clk); #1;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_hex_ledr();
        exp_t x; logic [32:0] o;
        wr(A_LEDR, 32'h3FF);
        wr(A_HEX, 32'h123456);
        push_exp("ledr_port", 33'(10'h3FF));
        push_exp("hex_port", 33'(24'h123456));
        @(negedge clk);
        obs_q.push_back(33'(LEDR));
        obs_q.push_back(33'(HEX));
        @(posedge clk); #1;
        rd("ledr_rd", A_LEDR, 1'b0, m(32'h3FF));
        rd("hex_rd",  A_HEX,  1'b0, m(32'h123456));
        wr(A_NONE, 32'hDEADBEEF);
        rd("unmapped_wr", A_NONE, 1'b0, 33'h0);
        rd("hex_after_unmapped", A_HEX, 1'b0, m(32'h123456));
        wr(A_LEDR, 32'hFFFFFC01);
        rd("ledr_trunc", A_LEDR, 1'b0, m(32'h001));
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_key();
        exp_t x; logic [32:0] o;
        KEY = 4'b1110;
        cyc(2);
        rd("key_lat_early", A_KDATA, 1'b0, m(32'h0));
        rd("key_kdata",     A_KDATA, 1'b0, m(32'h1));
        rd("key_ready",     A_KCTRL, 1'b0, m(32'h1));
        KEY = 4'b1100;
        cyc(3);
        rd("key_overrun",   A_KCTRL, 1'b0, m(32'h5));
        rd("key_kdata2",    A_KDATA, 1'b0, m(32'h3));
        rd("key_load",      A_KDATA, 1'b1, m(32'h3));
        rd("key_rdclr",     A_KCTRL, 1'b0, m(32'h4));
        wr(A_KCTRL, 32'h5);
        rd("key_w1_noeff",  A_KCTRL, 1'b0, m(32'h4));
        wr(A_KCTRL, 32'h0);
        rd("key_w0c",       A_KCTRL, 1'b0, m(32'h0));
        KEY = 4'b1111;
        cyc(3);
        rd("key_release",   A_KCTRL, 1'b0, m(32'h1));
        KEY = 4'b1110;
        cyc(2);
        rd("key_load_evt",  A_KDATA, 1'b1, m(32'h0));
        rd("key_evt_wins",  A_KCTRL, 1'b0, m(32'h1));
        rd("key_kdata3",    A_KDATA, 1'b0, m(32'h1));
        wr(A_KCTRL, 32'h0);
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_sw();
        exp_t x; logic [32:0] o;
        SW = 10'h001;
        cyc(2);
        SW = 10'h000;
        cyc(6);
        rd("sw_glitch_sdata", A_SDATA, 1'b0, m(32'h0));
        rd("sw_glitch_sctrl", A_SCTRL, 1'b0, m(32'h0));
        SW = 10'h001;
        cyc(5);
        rd("sw_not_yet",  A_SDATA, 1'b0, m(32'h0));
        rd("sw_loaded",   A_SDATA, 1'b0, m(32'h1));
        rd("sw_ready",    A_SCTRL, 1'b0, m(32'h1));
        rd("sw_load",     A_SDATA, 1'b1, m(32'h1));
        rd("sw_rdclr",    A_SCTRL, 1'b0, m(32'h0));
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_timer();
        exp_t x; logic [32:0] o;
        wr(A_TLIM, 32'd3);
        for (int i = 0; i < 16; i++)
            rd("tcnt_lim3", A_TCNT, 1'b0, m(32'((i / 4) % 3)));
        rd("tctl_first_wrap", A_TCTL, 1'b0, m(32'h1));
        cyc(7);
        rd("tctl_second_wrap", A_TCTL, 1'b0, m(32'h5));
        rd("tcnt_after_wrap",  A_TCNT, 1'b0, m(32'h0));
        rw("tctl_rw_prewrite", A_TCTL, 32'h0, m(32'h5));
        rd("tctl_cleared",     A_TCTL, 1'b0, m(32'h0));
        wr(A_TLIM, 32'd0);
        wr(A_TCNT, 32'd7);
        for (int i = 0; i < 10; i++)
            rd("tcnt_free", A_TCNT, 1'b0, m(32'(7 + i / 4)));
        cyc(1);
        wr(A_TCNT, 32'h20);
        rd("tcnt_wr_over_tick", A_TCNT, 1'b0, m(32'h20));
        wr(A_TCNT, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++)
            rd("tcnt_rollover", A_TCNT, 1'b0, m((i < 4) ? 32'hFFFFFFFF : 32'h0));
        rd("tctl_no_ready_free", A_TCTL, 1'b0, m(32'h0));
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_irq();
        exp_t x; logic [32:0] o;
        wr(A_TCTL, 32'h100);
`ifdef MMIO_IRQ_EN
        rd("tctl_ie", A_TCTL, 1'b0, m(32'h100));
        wr(A_TLIM, 32'd2);
        for (int i = 0; i < 11; i++) begin
            push_exp("irq_rise", 33'(i >= 9));
            @(negedge clk);
            obs_q.push_back(33'(irq));
            @(posedge clk); #1;
        end
        rd("tctl_ie_ready", A_TCTL, 1'b0, m(32'h101));
        wr(A_TCTL, 32'h100);
        for (int i = 0; i < 2; i++) begin
            push_exp("irq_fall", 33'(i == 0));
            @(negedge clk);
            obs_q.push_back(33'(irq));
            @(posedge clk); #1;
        end
        wr(A_TLIM, 32'd0);
`else
        rd("tctl_ie_ignored", A_TCTL, 1'b0, m(32'h0));
`endif
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t x; logic [32:0] o;
        wr(A_LEDR, 32'h2AA);
        wr(A_HEX,  32'hABCDEF);
        wr(A_LEDR, 32'h155);
        rd("b2b_ledr", A_LEDR, 1'b0, m(32'h155));
        rd("b2b_hex",  A_HEX,  1'b0, m(32'hABCDEF));
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== x.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", x.name, o, x.exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        KEY = 4'b1111; SW = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_hex_ledr();
        test_key();
        test_sw();
        test_timer();
        test_irq();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
